// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter
// Shares the two register-file write ports between the two in-order
// writeback lanes and a FIFO of long-latency results (mul/div/CP0).
// Lanes always win a port; queued results drain through whatever ports the
// lanes leave free, at most two per cycle, in FIFO order.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wb0_* / wb1_*              lane 0 (older) / lane 1 (younger) writes
//   ll_valid/ll_num/ll_data    long-latency result offer
//   ll_ready                   queue has room (from registered count only)
//   rf_we0/waddr0/wdata0       RF write port 0 (registered)
//   rf_we1/waddr1/wdata1       RF write port 1 (registered)
//   ll_pending_mask            registers targeted by queued results
//   wb_stall                   registered bubble request when the queue starves
module gpr_write_arbiter #(
  parameter int LL_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_we,
  input  logic [4:0]  wb0_num,
  input  logic [31:0] wb0_data,
  input  logic        wb1_we,
  input  logic [4:0]  wb1_num,
  input  logic [31:0] wb1_data,
  input  logic        ll_valid,
  input  logic [4:0]  ll_num,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  output logic        rf_we0,
  output logic [4:0]  rf_waddr0,
  output logic [31:0] rf_wdata0,
  output logic        rf_we1,
  output logic [4:0]  rf_waddr1,
  output logic [31:0] rf_wdata1,
  output logic [31:0] ll_pending_mask,
  output logic        wb_stall
);

  localparam int PW = $clog2(LL_DEPTH);
  localparam int CW = $clog2(LL_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Pointers wrap modulo LL_DEPTH, so non-power-of-two depths work too.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(LL_DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1'b1);
    end
  endfunction

  // A queued value whose register is being written by a lane this cycle is dead.
  function automatic logic lane_hit(input logic [4:0] n,
                                    input logic e0, input logic [4:0] a0,
                                    input logic e1, input logic [4:0] a1);
    lane_hit = (e0 && (n == a0)) || (e1 && (n == a1));
  endfunction

  logic [4:0]          q_num_r  [LL_DEPTH];
  logic [31:0]         q_data_r [LL_DEPTH];
  logic [LL_DEPTH-1:0] q_valid_r;
  logic [PW-1:0]       head_r, tail_r, second_s;
  logic [CW-1:0]       count_r, count_next_s;
  logic [SW-1:0]       starve_r, starve_next_s;

  logic        rf_we0_r, rf_we1_r, wb_stall_r;
  logic [4:0]  rf_waddr0_r, rf_waddr1_r;
  logic [31:0] rf_wdata0_r, rf_wdata1_r;

  logic        w0_eff_s, w1_eff_s, w1_raw_s, push_s, ll_ready_s;
  logic        pop0_s, pop1_s, head_port_s, free0_s, free1_s;
  logic        p0_ll_s, p1_ll_s;
  logic [4:0]  p0_num_s, p1_num_s, h_num_s, s_num_s;
  logic [31:0] p0_data_s, p1_data_s, mask_s;
  logic        rf_we0_s, rf_we1_s;
  logic [4:0]  rf_waddr0_s, rf_waddr1_s;
  logic [31:0] rf_wdata0_s, rf_wdata1_s;

  // Lane 0 is dropped when both lanes hit the same register: younger wins.
  assign w1_raw_s   = wb1_we && (wb1_num != 5'd0);
  assign w1_eff_s   = w1_raw_s;
  assign w0_eff_s   = wb0_we && (wb0_num != 5'd0) && !(w1_raw_s && (wb0_num == wb1_num));
  assign ll_ready_s = (count_r < CW'(LL_DEPTH));
  assign push_s     = ll_valid && ll_ready_s && (ll_num != 5'd0);
  assign second_s   = ptr_inc(head_r);
  assign h_num_s    = q_num_r[head_r];
  assign s_num_s    = q_num_r[second_s];

  // Drain decision: head first, second only if the head left the queue.
  always_comb begin
    pop0_s      = 1'b0;
    pop1_s      = 1'b0;
    head_port_s = 1'b0;
    free0_s     = !w0_eff_s;
    free1_s     = !w1_eff_s;
    p0_ll_s     = 1'b0;
    p1_ll_s     = 1'b0;
    p0_num_s    = 5'd0;
    p1_num_s    = 5'd0;
    p0_data_s   = 32'd0;
    p1_data_s   = 32'd0;
    if (count_r != CW'(1'b0)) begin
      if (lane_hit(h_num_s, w0_eff_s, wb0_num, w1_eff_s, wb1_num)) begin
        pop0_s = 1'b1;
      end else if (free0_s) begin
        pop0_s = 1'b1; head_port_s = 1'b1; free0_s = 1'b0;
        p0_ll_s = 1'b1; p0_num_s = h_num_s; p0_data_s = q_data_r[head_r];
      end else if (free1_s) begin
        pop0_s = 1'b1; head_port_s = 1'b1; free1_s = 1'b0;
        p1_ll_s = 1'b1; p1_num_s = h_num_s; p1_data_s = q_data_r[head_r];
      end else begin
        pop0_s = 1'b0;
      end
    end else begin
      pop0_s = 1'b0;
    end
    // Same-register second entry waits when the head really writes, so the
    // two RF ports never carry the same register with different ages.
    if (pop0_s && (count_r >= CW'(2'd2))) begin
      if (lane_hit(s_num_s, w0_eff_s, wb0_num, w1_eff_s, wb1_num)) begin
        pop1_s = 1'b1;
      end else if (head_port_s && (s_num_s == h_num_s)) begin
        pop1_s = 1'b0;
      end else if (free0_s) begin
        pop1_s = 1'b1;
        p0_ll_s = 1'b1; p0_num_s = s_num_s; p0_data_s = q_data_r[second_s];
      end else if (free1_s) begin
        pop1_s = 1'b1;
        p1_ll_s = 1'b1; p1_num_s = s_num_s; p1_data_s = q_data_r[second_s];
      end else begin
        pop1_s = 1'b0;
      end
    end else begin
      pop1_s = 1'b0;
    end
  end

  // Next RF port contents: lane data on its own port, else a drained entry.
  always_comb begin
    rf_we0_s    = w0_eff_s || p0_ll_s;
    rf_we1_s    = w1_eff_s || p1_ll_s;
    rf_waddr0_s = p0_num_s;
    rf_wdata0_s = p0_data_s;
    rf_waddr1_s = p1_num_s;
    rf_wdata1_s = p1_data_s;
    if (w0_eff_s) begin
      rf_waddr0_s = wb0_num;
      rf_wdata0_s = wb0_data;
    end else begin
      rf_waddr0_s = p0_num_s;
    end
    if (w1_eff_s) begin
      rf_waddr1_s = wb1_num;
      rf_wdata1_s = wb1_data;
    end else begin
      rf_waddr1_s = p1_num_s;
    end
  end

  // Occupancy and starvation counter next state.
  always_comb begin
    count_next_s = count_r + CW'(push_s) - CW'(pop0_s) - CW'(pop1_s);
    if ((count_r == CW'(1'b0)) || pop0_s) begin
      starve_next_s = SW'(1'b0);
    end else if (starve_r == SW'(STARVE_LIMIT)) begin
      starve_next_s = starve_r;
    end else begin
      starve_next_s = starve_r + SW'(1'b1);
    end
  end

  // Pending mask: OR of one-hot decodes of the valid entries, r0 excluded.
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      mask_s = mask_s | (q_valid_r[i] ? (32'd1 << q_num_r[i]) : 32'd0);
    end
    mask_s = mask_s & ~32'd1;
  end

  // Queue control, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid_r   <= '0;
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      starve_r    <= {SW{1'b0}};
      wb_stall_r  <= 1'b0;
      rf_we0_r    <= 1'b0;
      rf_waddr0_r <= 5'd0;
      rf_wdata0_r <= 32'd0;
      rf_we1_r    <= 1'b0;
      rf_waddr1_r <= 5'd0;
      rf_wdata1_r <= 32'd0;
    end else begin
      if (pop0_s) q_valid_r[head_r] <= 1'b0;
      if (pop1_s) q_valid_r[second_s] <= 1'b0;
      if (push_s) q_valid_r[tail_r] <= 1'b1;
      if (pop1_s) begin
        head_r <= ptr_inc(second_s);
      end else if (pop0_s) begin
        head_r <= second_s;
      end
      if (push_s) tail_r <= ptr_inc(tail_r);
      count_r     <= count_next_s;
      starve_r    <= starve_next_s;
      wb_stall_r  <= (starve_next_s == SW'(STARVE_LIMIT));
      rf_we0_r    <= rf_we0_s;
      rf_waddr0_r <= rf_waddr0_s;
      rf_wdata0_r <= rf_wdata0_s;
      rf_we1_r    <= rf_we1_s;
      rf_waddr1_r <= rf_waddr1_s;
      rf_wdata1_r <= rf_wdata1_s;
    end
  end

  // Queue payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_num_r[tail_r]  <= ll_num;
      q_data_r[tail_r] <= ll_data;
    end
  end

  assign ll_ready        = ll_ready_s;
  assign rf_we0          = rf_we0_r;
  assign rf_waddr0       = rf_waddr0_r;
  assign rf_wdata0       = rf_wdata0_r;
  assign rf_we1          = rf_we1_r;
  assign rf_waddr1       = rf_waddr1_r;
  assign rf_wdata1       = rf_wdata1_r;
  assign ll_pending_mask = mask_s;
  assign wb_stall        = wb_stall_r;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Testbench for gpr_write_arbiter: directed scenarios plus randomized traffic,
// every cycle compared with a queue-based reference model.
module tb_gpr_write_arbiter;
  localparam int D = 4;
  localparam int LIM = 8;

  logic clk, rst;
  logic wb0_we, wb1_we, ll_valid;
  logic [4:0] wb0_num, wb1_num, ll_num;
  logic [31:0] wb0_data, wb1_data, ll_data;
  logic ll_ready, rf_we0, rf_we1, wb_stall;
  logic [4:0] rf_waddr0, rf_waddr1;
  logic [31:0] rf_wdata0, rf_wdata1, ll_pending_mask;

  gpr_write_arbiter #(.LL_DEPTH(D), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .wb0_we(wb0_we), .wb0_num(wb0_num), .wb0_data(wb0_data),
    .wb1_we(wb1_we), .wb1_num(wb1_num), .wb1_data(wb1_data),
    .ll_valid(ll_valid), .ll_num(ll_num), .ll_data(ll_data),
    .ll_ready(ll_ready),
    .rf_we0(rf_we0), .rf_waddr0(rf_waddr0), .rf_wdata0(rf_wdata0),
    .rf_we1(rf_we1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
    .ll_pending_mask(ll_pending_mask), .wb_stall(wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] num; logic [31:0] data; } ent_t;
  ent_t mq[$];
  logic        m_we [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_starve;
  logic        m_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int p = 0; p < 2; p++) begin
      m_we[p] = 1'b0; m_addr[p] = 5'd0; m_data[p] = 32'd0;
    end
    m_starve = 0;
    m_stall  = 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] em;
    em = 32'd0;
    foreach (mq[i]) em[mq[i].num] = 1'b1;
    check_val("we0", {31'd0, rf_we0}, {31'd0, m_we[0]});
    if (m_we[0]) begin
      check_val("waddr0", {27'd0, rf_waddr0}, {27'd0, m_addr[0]});
      check_val("wdata0", rf_wdata0, m_data[0]);
    end
    check_val("we1", {31'd0, rf_we1}, {31'd0, m_we[1]});
    if (m_we[1]) begin
      check_val("waddr1", {27'd0, rf_waddr1}, {27'd0, m_addr[1]});
      check_val("wdata1", rf_wdata1, m_data[1]);
    end
    check_val("stall", {31'd0, wb_stall}, {31'd0, m_stall});
    check_val("mask", ll_pending_mask, em);
    check_val("ready", {31'd0, ll_ready}, {31'd0, (mq.size() < D)});
  endtask

  // One clock: model the edge from current inputs, then compare after it.
  task automatic cycle();
    logic e0, e1, push, hport, go;
    int pops;
    logic [4:0] n;
    if (rst) begin
      @(posedge clk); #1;
      model_reset();
      check_all();
      return;
    end
    e0 = wb0_we && (wb0_num != 5'd0);
    e1 = wb1_we && (wb1_num != 5'd0);
    if (e0 && e1 && wb0_num == wb1_num) e0 = 1'b0;
    m_we[0] = e0; m_addr[0] = wb0_num; m_data[0] = wb0_data;
    m_we[1] = e1; m_addr[1] = wb1_num; m_data[1] = wb1_data;
    push = ll_valid && (mq.size() < D) && (ll_num != 5'd0);
    pops = 0; hport = 1'b0; go = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (go && mq.size() > k) begin
        n = mq[k].num;
        if ((e0 && n == wb0_num) || (e1 && n == wb1_num)) pops++;
        else if (k == 1 && hport && n == mq[0].num) go = 1'b0;
        else if (!m_we[0]) begin
          m_we[0] = 1'b1; m_addr[0] = n; m_data[0] = mq[k].data; pops++;
          if (k == 0) hport = 1'b1;
        end else if (!m_we[1]) begin
          m_we[1] = 1'b1; m_addr[1] = n; m_data[1] = mq[k].data; pops++;
          if (k == 0) hport = 1'b1;
        end else go = 1'b0;
      end
    end
    if (mq.size() == 0 || pops > 0) m_starve = 0;
    else if (m_starve < LIM) m_starve++;
    m_stall = (m_starve == LIM);
    repeat (pops) void'(mq.pop_front());
    if (push) mq.push_back({ll_num, ll_data});
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic lanes(input logic we0, input logic [4:0] n0, input logic [31:0] d0,
                       input logic we1, input logic [4:0] n1, input logic [31:0] d1);
    wb0_we = we0; wb0_num = n0; wb0_data = d0;
    wb1_we = we1; wb1_num = n1; wb1_data = d1;
  endtask

  task automatic offer(input logic v, input logic [4:0] n, input logic [31:0] d);
    ll_valid = v; ll_num = n; ll_data = d;
  endtask

  task automatic async_reset();
    rst = 1'b1; #1;
    model_reset();
    check_val("rst_we0", {31'd0, rf_we0}, 32'd0);
    check_val("rst_we1", {31'd0, rf_we1}, 32'd0);
    check_val("rst_ready", {31'd0, ll_ready}, 32'd1);
    check_val("rst_mask", ll_pending_mask, 32'd0);
    check_val("rst_stall", {31'd0, wb_stall}, 32'd0);
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rnum();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  int busy;

  initial begin
    rst = 1'b1;
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    offer(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    model_reset();
    check_val("init_we0", {31'd0, rf_we0}, 32'd0);
    check_val("init_waddr0", {27'd0, rf_waddr0}, 32'd0);
    check_val("init_wdata1", rf_wdata1, 32'd0);
    check_val("init_ready", {31'd0, ll_ready}, 32'd1);
    check_all();
    rst = 1'b0;

    // Same register on both lanes: younger lane wins.
    lanes(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    cycle();
    check_val("t1_we0", {31'd0, rf_we0}, 32'd0);
    check_val("t1_we1", {31'd0, rf_we1}, 32'd1);
    check_val("t1_waddr1", {27'd0, rf_waddr1}, 32'd3);
    check_val("t1_wdata1", rf_wdata1, 32'h22);

    // Idle lanes: r5 then r6 drain through port 0.
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    offer(1'b1, 5'd5, 32'hA); cycle();
    check_val("t2_mask5", ll_pending_mask, 32'h20);
    offer(1'b1, 5'd6, 32'hB); cycle();
    check_val("t2_r5", {27'd0, rf_waddr0}, 32'd5);
    check_val("t2_mask6", ll_pending_mask, 32'h40);
    offer(1'b0, 5'd0, 32'd0); cycle();
    check_val("t2_r6", rf_wdata0, 32'hB);
    check_val("t2_mask0", ll_pending_mask, 32'd0);

    // r7/r8 queued; lane 0 busy -> r7 on port 1, r8 held.
    lanes(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
    offer(1'b1, 5'd7, 32'h77); cycle();
    offer(1'b1, 5'd8, 32'h88); cycle();
    offer(1'b0, 5'd0, 32'd0);
    lanes(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'd0); cycle();
    check_val("t3_r7port1", {27'd0, rf_waddr1}, 32'd7);
    check_val("t3_r8held", ll_pending_mask, 32'h100);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); cycle();
    check_val("t3_r8port0", {27'd0, rf_waddr0}, 32'd8);

    // Head r9 killed by lane 1 writing r9.
    lanes(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    offer(1'b1, 5'd9, 32'h99); cycle();
    offer(1'b0, 5'd0, 32'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h5); cycle();
    check_val("t4_we0", {31'd0, rf_we0}, 32'd0);
    check_val("t4_wdata1", rf_wdata1, 32'h5);
    check_val("t4_mask", ll_pending_mask, 32'd0);

    // Starvation: lanes busy with unrelated registers.
    lanes(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    offer(1'b1, 5'd20, 32'h2020); cycle();
    for (int i = 1; i <= 10; i++) begin
      offer(i == 1, 5'd21, 32'h2121);
      cycle();
      if (i == 7) check_val("t5_stall7", {31'd0, wb_stall}, 32'd0);
      if (i == 8) check_val("t5_stall8", {31'd0, wb_stall}, 32'd1);
    end
    offer(1'b0, 5'd0, 32'd0);
    lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); cycle();
    check_val("t5_stall_fall", {31'd0, wb_stall}, 32'd0);
    check_val("t5_drain", {27'd0, rf_waddr0}, 32'd20);

    // Fill queue, then asynchronous reset mid-stream.
    lanes(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    for (int i = 0; i < D; i++) begin
      offer(1'b1, 5'(10 + i), 32'(i)); cycle();
    end
    check_val("t6_full", {31'd0, ll_ready}, 32'd0);
    async_reset();

    // Randomized traffic.
    busy = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) busy = $urandom_range(0, 4);
      lanes($urandom_range(0, 3) < busy, rnum(), $urandom(),
            $urandom_range(0, 3) < busy, rnum(), $urandom());
      offer($urandom_range(0, 2) != 0, rnum(), $urandom());
      cycle();
      if (i == 1500) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
